// File: rtl/bbox_pkg.sv
// ============================================================================
// Module : bbox_pkg
// Brief  : Shared screen geometry defaults and scanner state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bbox_pkg;

    localparam int DEF_X_WIDTH  = 10;
    localparam int DEF_Y_WIDTH  = 9;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BBOX = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bbox_scanner_cmp.sv
// ============================================================================
// Module : bbox_min3 / bbox_max3
// Brief  : Unsigned three-input minimum and maximum selectors.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbox_min3 #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] y_o
);
    logic [WIDTH-1:0] w_ab;

    assign w_ab = (a_i < b_i) ? a_i : b_i;
    assign y_o  = (w_ab < c_i) ? w_ab : c_i;
endmodule

module bbox_max3 #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] y_o
);
    logic [WIDTH-1:0] w_ab;

    assign w_ab = (a_i > b_i) ? a_i : b_i;
    assign y_o  = (w_ab > c_i) ? w_ab : c_i;
endmodule

`default_nettype wire

// File: rtl/bbox_scanner.sv
// ============================================================================
// Module : bbox_scanner
// Brief  : Walks the screen-clipped bounding box of a triangle in raster order.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbox_scanner
    import bbox_pkg::*;
#(
    parameter int X_WIDTH  = DEF_X_WIDTH,
    parameter int Y_WIDTH  = DEF_Y_WIDTH,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [X_WIDTH-1:0] x0,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y0,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [Y_WIDTH-1:0] y2,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_WIDTH-1:0] pix_x,
    output logic [Y_WIDTH-1:0] pix_y,
    output logic               pix_last,
    output logic               busy
);

    localparam logic [X_WIDTH-1:0] c_x_lim = X_WIDTH'(SCREEN_W - 1);
    localparam logic [Y_WIDTH-1:0] c_y_lim = Y_WIDTH'(SCREEN_H - 1);
    localparam logic [X_WIDTH-1:0] c_x_one = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] c_y_one = Y_WIDTH'(1);

    state_t state_q, state_d;

    logic [X_WIDTH-1:0] x0_q, x1_q, x2_q, x0_d, x1_d, x2_d;
    logic [Y_WIDTH-1:0] y0_q, y1_q, y2_q, y0_d, y1_d, y2_d;
    logic [X_WIDTH-1:0] xmin_q, xmax_q, cur_x_q, xmin_d, xmax_d, cur_x_d;
    logic [Y_WIDTH-1:0] ymin_q, ymax_q, cur_y_q, ymin_d, ymax_d, cur_y_d;

    logic [X_WIDTH-1:0] w_xmin, w_xmax_raw, w_xmax;
    logic [Y_WIDTH-1:0] w_ymin, w_ymax_raw, w_ymax;
    logic               w_offscreen;
    logic               w_hs;
    logic               w_x_end;
    logic               w_y_end;

    bbox_min3 #(.WIDTH(X_WIDTH)) u_xmin (.a_i(x0_q), .b_i(x1_q), .c_i(x2_q), .y_o(w_xmin));
    bbox_max3 #(.WIDTH(X_WIDTH)) u_xmax (.a_i(x0_q), .b_i(x1_q), .c_i(x2_q), .y_o(w_xmax_raw));
    bbox_min3 #(.WIDTH(Y_WIDTH)) u_ymin (.a_i(y0_q), .b_i(y1_q), .c_i(y2_q), .y_o(w_ymin));
    bbox_max3 #(.WIDTH(Y_WIDTH)) u_ymax (.a_i(y0_q), .b_i(y1_q), .c_i(y2_q), .y_o(w_ymax_raw));

    // Clamping the max edges keeps xmax >= xmin whenever the box is on-screen.
    assign w_xmax      = (w_xmax_raw > c_x_lim) ? c_x_lim : w_xmax_raw;
    assign w_ymax      = (w_ymax_raw > c_y_lim) ? c_y_lim : w_ymax_raw;
    assign w_offscreen = (w_xmin > c_x_lim) || (w_ymin > c_y_lim);

    assign w_hs    = (state_q == ST_SCAN) && pix_ready;
    assign w_x_end = (cur_x_q == xmax_q);
    assign w_y_end = (cur_y_q == ymax_q);

    assign tri_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign pix_valid = (state_q == ST_SCAN);
    assign pix_last  = (state_q == ST_SCAN) && w_x_end && w_y_end;
    assign pix_x     = cur_x_q;
    assign pix_y     = cur_y_q;

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;

        case (state_q)
            ST_IDLE: begin
                if (tri_valid) begin
                    x0_d    = x0;
                    x1_d    = x1;
                    x2_d    = x2;
                    y0_d    = y0;
                    y1_d    = y1;
                    y2_d    = y2;
                    state_d = ST_BBOX;
                end
            end
            ST_BBOX: begin
                xmin_d = w_xmin;
                xmax_d = w_xmax;
                ymin_d = w_ymin;
                ymax_d = w_ymax;
                if (w_offscreen) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_x_d = w_xmin;
                    cur_y_d = w_ymin;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_hs) begin
                    if (!w_x_end) begin
                        cur_x_d = cur_x_q + c_x_one;
                    end else if (!w_y_end) begin
                        cur_x_d = xmin_q;
                        cur_y_d = cur_y_q + c_y_one;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
        end
    end

endmodule

`default_nettype wire
